// File: rtl/progmem_pkg.sv
// Shared types and defaults for the program memory: FSM state encoding,
// the NOP word returned on bad fetches, and default geometry.
package progmem_pkg;

    localparam int PM_DATA_WIDTH = 32;
    localparam int PM_ADDR_WIDTH = 10;
    localparam int PM_DEPTH      = 1024;

    localparam logic [PM_DATA_WIDTH-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } pm_state_e;

    // Index width needed to address 'depth' entries (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/progmem_array.sv
// Simple dual-port storage: one synchronous write port and one synchronous
// read port whose output register holds while rd_en is low. No reset, no init.
module progmem_array
    import progmem_pkg::*;
#(
    parameter int WIDTH      = PM_DATA_WIDTH,
    parameter int DEPTH      = PM_DEPTH,
    parameter int ADDR_WIDTH = idx_width(PM_DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/program_memory.sv
// Loadable instruction memory with a 1-cycle fetch port and a streaming load
// port. Define PROGMEM_PARITY_EN to store an even-parity bit per word and expose parity_err.
module program_memory
    import progmem_pkg::*;
#(
    parameter int DATA_WIDTH = PM_DATA_WIDTH,
    parameter int ADDR_WIDTH = PM_ADDR_WIDTH,
    parameter int DEPTH      = PM_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    output logic                  addr_err,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  busy,
    output logic                  load_done
`ifdef PROGMEM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

`ifdef PROGMEM_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif
    localparam int IDX_WIDTH = idx_width(DEPTH);
    localparam int AW1       = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = AW1'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = AW1'(DEPTH - 1);

    pm_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  load_ready_q, load_ready_d;
    logic                  busy_q, busy_d;
    logic                  load_done_q, load_done_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  addr_err_q, addr_err_d;
    logic                  nop_sel_q, nop_sel_d;

    logic                  fetch_ok;
    logic                  fetch_in_range;
    logic                  wr_en;
    logic [MEM_WIDTH-1:0]  mem_wdata;
    logic [MEM_WIDTH-1:0]  mem_rdata;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        count_d        = count_q;
        wr_en          = 1'b0;
        fetch_ok       = fetch_en && (state_q == ST_IDLE);
        fetch_in_range = ({1'b0, fetch_addr} < DEPTH_W);
        fetch_valid_d  = fetch_ok;
        addr_err_d     = addr_err_q;
        nop_sel_d      = nop_sel_q;

        // nop_sel steers the output to NOP_WORD after reset and after bad fetches
        if (fetch_ok) begin
            addr_err_d = !fetch_in_range;
            nop_sel_d  = !fetch_in_range;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    addr_d  = load_base;
                    count_d = load_count;
                    state_d = (load_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    wr_en   = ({1'b0, addr_q} < DEPTH_W);
                    addr_d  = ({1'b0, addr_q} == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    count_d = count_q - 1'b1;
                    if (count_q == AW1'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered copies of the state being entered
        load_ready_d = (state_d == ST_LOAD);
        busy_d       = (state_d == ST_LOAD);
        load_done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            load_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            nop_sel_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            load_ready_q  <= load_ready_d;
            busy_q        <= busy_d;
            load_done_q   <= load_done_d;
            fetch_valid_q <= fetch_valid_d;
            addr_err_q    <= addr_err_d;
            nop_sel_q     <= nop_sel_d;
        end
    end

`ifdef PROGMEM_PARITY_EN
    assign mem_wdata  = {^load_data, load_data};
    assign parity_err = fetch_valid_q && !nop_sel_q && (^mem_rdata);
`else
    assign mem_wdata  = load_data;
`endif

    progmem_array #(
        .WIDTH      (MEM_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (IDX_WIDTH)
    ) u_array (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (addr_q[IDX_WIDTH-1:0]),
        .wr_data (mem_wdata),
        .rd_en   (fetch_ok && fetch_in_range),
        .rd_addr (fetch_addr[IDX_WIDTH-1:0]),
        .rd_data (mem_rdata)
    );

    assign fetch_data  = nop_sel_q ? DATA_WIDTH'(NOP_WORD) : mem_rdata[DATA_WIDTH-1:0];
    assign fetch_valid = fetch_valid_q;
    assign addr_err    = addr_err_q;
    assign load_ready  = load_ready_q;
    assign busy        = busy_q;
    assign load_done   = load_done_q;

endmodule
